// File: rtl/led_mode_sequencer.sv
// ---------------------------------------------------------------------------
// led_mode_sequencer
//
// Selects what the board LED mux shows (debug view vs. morse view) and keeps
// a short shift history of the received morse line.  A debounced mode button
// toggles between the views, a CPU fault forces the debug view, and (when
// LED_AUTO_SWITCH_EN is defined) link activity auto-enters the morse view and
// an idle timeout returns to debug.
//
// Optional feature macro: LED_AUTO_SWITCH_EN
//   defined   : activity enters MORSE_AUTO, idle timeout leaves it
//   undefined : only press and fault change state; idle counter removed
//
// Ports
//   clk              in   system clock
//   rst_n            in   asynchronous active-low reset
//   mode_btn_n       in   raw mode push-button, active-low, asynchronous
//   morse_code_in    in   raw received morse line, asynchronous
//   morse_code_out   in   transmitted morse line, clk-synchronous
//   fault            in   CPU fault flag, clk-synchronous
//   led_select       out  0 = debug view, 1 = morse view
//   receive_history  out  last 8 samples of morse_code_in, bit0 newest
//   sample_tick      out  one-cycle pulse at each sample instant
//   mode_state       out  current FSM state encoding
//
// state        | meaning
// -------------+----------------------------------------------------------
// DEBUG (0)    | debug view shown, waiting for press or link activity
// MANUAL (1)   | morse view selected by the user
// AUTO (2)     | morse view entered by link activity, returns after idle
// FORCED (3)   | debug view forced by fault, left only by a press
// ---------------------------------------------------------------------------
module led_mode_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES    = 500000,
    parameter int unsigned SAMPLE_CYCLES      = 12500000,
    parameter int unsigned IDLE_TIMEOUT_UNITS = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode_btn_n,
    input  logic       morse_code_in,
    input  logic       morse_code_out,
    input  logic       fault,
    output logic       led_select,
    output logic [7:0] receive_history,
    output logic       sample_tick,
    output logic [1:0] mode_state
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned SMP_W = (SAMPLE_CYCLES > 1) ? $clog2(SAMPLE_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(SAMPLE_CYCLES - 1);

`ifdef LED_AUTO_SWITCH_EN
    localparam logic AUTO_EN = 1'b1;
`else
    localparam logic AUTO_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_DEBUG  = 2'd0,
        ST_MANUAL = 2'd1,
        ST_AUTO   = 2'd2,
        ST_FORCED = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    // ---------------------------------------------------------------- sync
    logic btn_meta, btn_sync;
    logic morse_meta, morse_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_meta   <= 1'b1;
            btn_sync   <= 1'b1;
            morse_meta <= 1'b0;
            morse_sync <= 1'b0;
        end else begin
            btn_meta   <= mode_btn_n;
            btn_sync   <= btn_meta;
            morse_meta <= morse_code_in;
            morse_sync <= morse_meta;
        end
    end

    // ------------------------------------------------------------ debounce
    // btn_last tracks the synced level so any change restarts the count;
    // btn_stable is the accepted level. Acceptance is decided on the next
    // count value so the press lands exactly DEBOUNCE_CYCLES after sync.
    logic            btn_last, btn_stable, press;
    logic [DB_W-1:0] db_cnt, db_cnt_next;
    logic            btn_changed, accept;

    always_comb begin
        btn_changed = (btn_sync != btn_last);
        db_cnt_next = db_cnt;
        if (btn_changed) begin
            db_cnt_next = '0;
        end else if (db_cnt != DB_LAST) begin
            db_cnt_next = db_cnt + DB_W'(1);
        end
        accept = !btn_changed && (db_cnt_next == DB_LAST) && (btn_last != btn_stable);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_last   <= 1'b1;
            btn_stable <= 1'b1;
            db_cnt     <= '0;
            press      <= 1'b0;
        end else begin
            btn_last <= btn_sync;
            db_cnt   <= db_cnt_next;
            press    <= accept && !btn_last;
            if (accept) begin
                btn_stable <= btn_last;
            end
        end
    end

    // ------------------------------------------------------------ activity
    logic morse_prev, out_prev;
    logic activity_raw, activity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            morse_prev <= 1'b0;
            out_prev   <= 1'b0;
        end else begin
            morse_prev <= morse_sync;
            out_prev   <= morse_code_out;
        end
    end

    assign activity_raw = (morse_sync & ~morse_prev) | (morse_code_out & ~out_prev);
    assign activity     = activity_raw & AUTO_EN;

    // ------------------------------------------------------- sample timing
    logic [SMP_W-1:0] smp_cnt;
    logic             smp_wrap;

    assign smp_wrap = (smp_cnt == SMP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp_cnt         <= '0;
            sample_tick     <= 1'b0;
            receive_history <= 8'h00;
        end else begin
            sample_tick <= smp_wrap;
            if (smp_wrap) begin
                smp_cnt         <= '0;
                receive_history <= {receive_history[6:0], morse_sync};
            end else begin
                smp_cnt <= smp_cnt + SMP_W'(1);
            end
        end
    end

    // -------------------------------------------------------- idle timeout
    logic idle_done;

`ifdef LED_AUTO_SWITCH_EN
    // One extra bit over $clog2 so the counter can actually hold the limit.
    localparam int unsigned IDLE_W = $clog2(IDLE_TIMEOUT_UNITS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT_UNITS);

    logic [IDLE_W-1:0] idle_cnt;
    logic              enter_auto;

    assign enter_auto = (state != ST_AUTO) && (state_next == ST_AUTO);
    assign idle_done  = (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (activity || enter_auto) begin
            idle_cnt <= '0;
        end else if (smp_wrap && !idle_done) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end
`else
    assign idle_done = 1'b0;
`endif

    // ----------------------------------------------------------------- FSM
    always_comb begin
        state_next = state;
        if (fault) begin
            state_next = ST_FORCED;
        end else begin
            unique case (state)
                ST_DEBUG: begin
                    if (press) begin
                        state_next = ST_MANUAL;
                    end else if (activity) begin
                        state_next = ST_AUTO;
                    end
                end
                ST_MANUAL: begin
                    if (press) state_next = ST_DEBUG;
                end
                ST_AUTO: begin
                    if (press || idle_done) state_next = ST_DEBUG;
                end
                ST_FORCED: begin
                    if (press) state_next = ST_DEBUG;
                end
                default: state_next = ST_DEBUG;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_DEBUG;
            led_select <= 1'b0;
        end else begin
            state      <= state_next;
            led_select <= (state_next == ST_MANUAL) || (state_next == ST_AUTO);
        end
    end

    assign mode_state = state;

endmodule
